div_8by4: RTL and testbench

- Sequential restoring divider. Takes an 8-bit dividend and a 4-bit divisor and produces an 8-bit quotient and a 4-bit remainder.
- It is the inverse-operation companion to the team's 4x4 shift-add multiplier core.
- It uses the same init/done handshake as the multiplier, so a Tiny Tapeout top-level wrapper can drive either core from ui_in/uio pins.
- One quotient bit is resolved per clock.

---
 rtl/div_8by4.sv | 132 +++++++++++++
 tb/tb_div_8by4.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_8by4.sv
// -----------------------------------------------------------------------------
// div_8by4 : sequential restoring divider, one quotient bit per clock.
//
// Divides an N-bit unsigned dividend by an M-bit unsigned divisor and returns
// an N-bit quotient and an M-bit remainder. It uses the same init/done
// handshake as the 4x4 shift-add multiplier core, so one wrapper can drive
// either core.
//
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous reset, active low
//   init     in   1  start request, level-sampled in IDLE
//   DD       in   N  dividend, captured on the start edge
//   DV       in   M  divisor, captured on the start edge
//   Q        out  N  quotient (registered, held until the next result)
//   R        out  M  remainder (registered, held until the next result)
//   done     out  1  result valid, high while in DONE
//   div_zero out  1  last operation had a zero divisor
// -----------------------------------------------------------------------------
module div_8by4 #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic [N-1:0] DD,
    input  logic [M-1:0] DV,
    output logic [N-1:0] Q,
    output logic [M-1:0] R,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_wq;     // working quotient; starts as the dividend
    logic [M:0]     r_p;      // partial remainder, one spare bit for 2*DV-1
    logic [M-1:0]   r_dv;     // divisor copy so DV may change during CALC
    logic [N-1:0]   r_q;
    logic [M-1:0]   r_r;
    logic           r_dz;

    logic [M+1:0]   w_sh;     // {P, Wq} shifted left, top M+2 bits
    logic [M:0]     w_p_sh;
    logic [M+1:0]   w_t;
    logic           w_fits;
    logic           w_last;
    logic [N-1:0]   w_wq_nxt;
    logic [M:0]     w_p_nxt;

    assign w_sh     = {r_p, r_wq[N-1]};
    assign w_p_sh   = w_sh[M:0];
    assign w_t      = w_sh - {2'b00, r_dv};
    // A clear sign bit means the trial subtraction did not underflow.
    assign w_fits   = ~w_t[M+1];
    assign w_p_nxt  = w_fits ? w_t[M:0] : w_p_sh;
    assign w_wq_nxt = {r_wq[N-2:0], w_fits};
    assign w_last   = (r_cnt == CW'(N - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (init) w_next = (DV != '0) ? S_CALC : S_DONE;
            S_CALC:  if (w_last) w_next = S_DONE;
            S_DONE:  if (!init) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_wq  <= '0;
            r_p   <= '0;
            r_dv  <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init) begin
                        if (DV != '0) begin
                            r_wq  <= DD;
                            r_p   <= '0;
                            r_cnt <= '0;
                            r_dv  <= DV;
                        end else begin
                            // Zero divisor: saturate and flag, skip CALC.
                            r_q  <= '1;
                            r_r  <= '1;
                            r_dz <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_p  <= w_p_nxt;
                    r_wq <= w_wq_nxt;
                    if (w_last) begin
                        r_cnt <= '0;
                        r_q   <= w_wq_nxt;
                        // Final remainder is < DV, so the spare bit is zero.
                        r_r   <= w_p_nxt[M-1:0];
                        r_dz  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q        = r_q;
    assign R        = r_r;
    assign div_zero = r_dz;
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_div_8by4.sv
// -----------------------------------------------------------------------------
// tb_div_8by4 : directed self-checking bench for div_8by4.
// -----------------------------------------------------------------------------
module tb_div_8by4;

    logic       clk = 1'b0;
    logic       rst;
    logic       init;
    logic [7:0] DD;
    logic [3:0] DV;
    logic [7:0] Q;
    logic [3:0] R;
    logic       done;
    logic       div_zero;

    int n_pass  = 0;
    int n_total = 0;

    div_8by4 dut (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .DD       (DD),
        .DV       (DV),
        .Q        (Q),
        .R        (R),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Present operands with init high for exactly the start edge.
    task automatic start_op(input logic [7:0] dd, input logic [3:0] dv);
        @(negedge clk);
        DD   = dd;
        DV   = dv;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
    endtask

    // Count edges after the start edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // One edge with init low takes DONE back to IDLE.
    task automatic back_to_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; init = 1'b0; DD = '0; DV = '0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({Q, R, done, div_zero} !== 14'd0)
            $display("FAIL reset_state: Q=%0d R=%0d done=%b dz=%b, want all 0", Q, R, done, div_zero);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_200_7();
        int lat;
        start_op(8'd200, 4'd7);
        wait_done(lat);
        n_total++;
        if (lat !== 8) $display("FAIL lat_200_7: got %0d edges, want 8", lat);
        else n_pass++;
        n_total++;
        if (Q !== 8'd28 || R !== 4'd4 || div_zero !== 1'b0)
            $display("FAIL res_200_7: Q=%0d R=%0d dz=%b, want 28 4 0", Q, R, div_zero);
        else n_pass++;
        back_to_idle();
    endtask

    task automatic test_extremes();
        logic [7:0] t_dd [5] = '{8'd255, 8'd5, 8'd0,  8'd255, 8'd9};
        logic [3:0] t_dv [5] = '{4'd1,   4'd9, 4'd15, 4'd15,  4'd2};
        logic [7:0] t_q  [5] = '{8'd255, 8'd0, 8'd0,  8'd17,  8'd4};
        logic [3:0] t_r  [5] = '{4'd0,   4'd5, 4'd0,  4'd0,   4'd1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_op(t_dd[i], t_dv[i]);
            wait_done(lat);
            n_total++;
            if (done !== 1'b1 || Q !== t_q[i] || R !== t_r[i] || div_zero !== 1'b0)
                $display("FAIL extreme_%0d_%0d: done=%b Q=%0d R=%0d dz=%b, want 1 %0d %0d 0",
                         t_dd[i], t_dv[i], done, Q, R, div_zero, t_q[i], t_r[i]);
            else n_pass++;
            back_to_idle();
        end
    endtask

    task automatic test_sweep();
        int lat, q, r;
        for (int dd = 0; dd < 256; dd++) begin
            for (int dv = 1; dv < 16; dv++) begin
                start_op(8'(dd), 4'(dv));
                wait_done(lat);
                q = int'(Q);
                r = int'(R);
                n_total++;
                if (done !== 1'b1 || lat !== 8 || q * dv + r !== dd || r >= dv || div_zero !== 1'b0)
                    $display("FAIL sweep_%0d_%0d: Q=%0d R=%0d lat=%0d dz=%b, want Q*DV+R=DD, R<DV, lat 8",
                             dd, dv, q, r, lat, div_zero);
                else n_pass++;
                back_to_idle();
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        start_op(8'h55, 4'd0);
        wait_done(lat);
        n_total++;
        if (lat !== 0 || Q !== 8'hFF || R !== 4'hF || div_zero !== 1'b1)
            $display("FAIL div_zero: lat=%0d Q=%h R=%h dz=%b, want 0 ff f 1", lat, Q, R, div_zero);
        else n_pass++;
        back_to_idle();
        start_op(8'd100, 4'd10);
        wait_done(lat);
        n_total++;
        if (lat !== 8 || Q !== 8'd10 || R !== 4'd0 || div_zero !== 1'b0)
            $display("FAIL after_div_zero: lat=%0d Q=%0d R=%0d dz=%b, want 8 10 0 0", lat, Q, R, div_zero);
        else n_pass++;
        back_to_idle();
    endtask

    task automatic test_handshake();
        int lat;
        // init held through 20 edges: one operation, done sticks while init=1.
        @(negedge clk);
        DD = 8'd100; DV = 4'd10; init = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin DD = 8'd7; DV = 4'd3; end
            n_total++;
            if (done !== (i >= 8))
                $display("FAIL held_init_done_e%0d: done=%b, want %b", i, done, (i >= 8));
            else n_pass++;
        end
        n_total++;
        if (Q !== 8'd10 || R !== 4'd0)
            $display("FAIL held_init_res: Q=%0d R=%0d, want 10 0", Q, R);
        else n_pass++;
        init = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (done !== 1'b0) $display("FAIL release_idle_%0d: done=%b, want 0", i, done);
            else n_pass++;
        end
        // Operand changes and an init pulse in CALC must not disturb the result.
        start_op(8'd200, 4'd7);
        repeat (2) begin @(posedge clk); #1; end
        DD = 8'd13; DV = 4'd0; init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        wait_done(lat);
        n_total++;
        if (lat + 3 !== 8 || Q !== 8'd28 || R !== 4'd4 || div_zero !== 1'b0)
            $display("FAIL calc_disturb: lat=%0d Q=%0d R=%0d dz=%b, want 8 28 4 0", lat + 3, Q, R, div_zero);
        else n_pass++;
        back_to_idle();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        start_op(8'd200, 4'd7);
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({Q, R, done, div_zero} !== 14'd0)
            $display("FAIL reset_mid_op: Q=%0d R=%0d done=%b dz=%b, want all 0", Q, R, done, div_zero);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (done !== 1'b0) $display("FAIL reset_no_done: done=%b, want 0", done);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        start_op(8'd9, 4'd2);
        wait_done(lat);
        n_total++;
        if (lat !== 8 || Q !== 8'd4 || R !== 4'd1)
            $display("FAIL after_reset_9_2: lat=%0d Q=%0d R=%0d, want 8 4 1", lat, Q, R);
        else n_pass++;
        back_to_idle();
    endtask

    task automatic test_result_hold();
        int lat;
        start_op(8'd200, 4'd7);
        wait_done(lat);
        back_to_idle();
        n_total++;
        if (Q !== 8'd28 || R !== 4'd4 || done !== 1'b0)
            $display("FAIL hold_idle: Q=%0d R=%0d done=%b, want 28 4 0", Q, R, done);
        else n_pass++;
        start_op(8'd13, 4'd3);
        for (int e = 1; e <= 8; e++) begin
            n_total++;
            if (Q !== 8'd28 || R !== 4'd4 || done !== 1'b0)
                $display("FAIL hold_calc_e%0d: Q=%0d R=%0d done=%b, want 28 4 0", e, Q, R, done);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        n_total++;
        if (done !== 1'b1 || Q !== 8'd4 || R !== 4'd1)
            $display("FAIL hold_update: done=%b Q=%0d R=%0d, want 1 4 1", done, Q, R);
        else n_pass++;
        back_to_idle();
    endtask

    initial begin
        test_reset();
        test_200_7();
        test_extremes();
        test_div_zero();
        test_handshake();
        test_reset_mid_op();
        test_result_hold();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
